// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access unit: funct3 sizes, FSM states,
// and helpers for access legality and store lane placement.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] BE_ALL = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  // Misaligned halfword/word, reserved funct3, or an unsigned size on a store.
  function automatic logic access_fault(input logic [2:0] funct3,
                                        input logic [1:0] offset,
                                        input logic       is_write);
    logic f;
    f = 1'b0;
    case (funct3)
      F3_B:    f = 1'b0;
      F3_BU:   f = is_write;
      F3_H:    f = offset[0];
      F3_HU:   f = is_write | offset[0];
      F3_W:    f = (offset != 2'b00);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] funct3,
                                          input logic [1:0] offset);
    logic [3:0] be;
    be = BE_ALL;
    case (funct3)
      F3_B:    be = 4'b0001 << offset;
      F3_H:    be = offset[1] ? 4'b1100 : 4'b0011;
      default: be = BE_ALL;
    endcase
    return be;
  endfunction

  // Memory picks the lane by byte enable, so the low bytes are replicated.
  function automatic logic [31:0] store_wdata(input logic [2:0]  funct3,
                                              input logic [31:0] data);
    logic [31:0] w;
    w = data;
    case (funct3)
      F3_B:    w = {4{data[7:0]}};
      F3_H:    w = {2{data[15:0]}};
      default: w = data;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// Load alignment: picks the addressed byte/halfword out of the read word and
// sign- or zero-extends it according to funct3.
module load_align
  import mem_access_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane select and extension.
  always_comb begin
    byte_sel = rdata[7:0];
    case (offset)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];

    case (funct3)
      F3_B:    data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data = {24'd0, byte_sel};
      F3_H:    data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator side of the data-memory port. Turns pipeline load/store requests
// into a valid/ready request to a variable-latency memory, stalls upstream
// while the access is in flight, and returns aligned load data.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no access in flight; legal request is latched, illegal faults
// REQ     | req_valid_out high, request fields frozen until req_ready_in
// RESP    | read accepted, waiting for resp_valid_in
// DONE    | release cycle: stall drops, load_valid_out pulses for reads
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [31:0]           store_data_in,
  input  logic [2:0]            funct3_in,
  input  logic                  memRead_in,
  input  logic                  memWrite_in,
  output logic                  stall_out,
  output logic [31:0]           load_data_out,
  output logic                  load_valid_out,
  output logic                  fault_out,
  output logic                  req_valid_out,
  input  logic                  req_ready_in,
  output logic                  req_write_out,
  output logic [ADDR_WIDTH-1:0] req_addr_out,
  output logic [31:0]           req_wdata_out,
  output logic [3:0]            req_be_out,
  input  logic                  resp_valid_in,
  input  logic [31:0]           resp_rdata_in
);

  state_t state_q, state_d;

  logic                  start;
  logic                  fault;
  logic                  latch_en;
  logic                  fault_set;
  logic                  load_en;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            offset_q;
  logic [2:0]            funct3_q;
  logic                  write_q;
  logic [3:0]            be_q;
  logic [31:0]           wdata_q;
  logic                  fault_q;
  logic [31:0]           load_data_q;
  logic [31:0]           aligned;

  assign start = memRead_in | memWrite_in;
  assign fault = access_fault(funct3_in, addr_in[1:0], memWrite_in);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and per-state strobes for the datapath registers.
  always_comb begin
    state_d   = state_q;
    latch_en  = 1'b0;
    fault_set = 1'b0;
    load_en   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (fault) begin
            fault_set = 1'b1;
          end else begin
            latch_en = 1'b1;
            state_d  = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (req_ready_in) state_d = write_q ? ST_DONE : ST_RESP;
      end
      ST_RESP: begin
        if (resp_valid_in) begin
          load_en = 1'b1;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  load_align u_load_align (
    .rdata  (resp_rdata_in),
    .offset (offset_q),
    .funct3 (funct3_q),
    .data   (aligned)
  );

  // Request fields are captured once at acceptance so they stay stable in REQ.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      offset_q    <= 2'b00;
      funct3_q    <= 3'b000;
      write_q     <= 1'b0;
      be_q        <= 4'b0000;
      wdata_q     <= 32'd0;
      fault_q     <= 1'b0;
      load_data_q <= 32'd0;
    end else begin
      fault_q <= fault_set;
      if (latch_en) begin
        addr_q   <= {addr_in[ADDR_WIDTH-1:2], 2'b00};
        offset_q <= addr_in[1:0];
        funct3_q <= funct3_in;
        write_q  <= memWrite_in;
        be_q     <= memWrite_in ? store_be(funct3_in, addr_in[1:0]) : BE_ALL;
        wdata_q  <= memWrite_in ? store_wdata(funct3_in, store_data_in) : 32'd0;
      end
      if (load_en) load_data_q <= aligned;
    end
  end

  // Stall is combinational in IDLE so the requesting instruction freezes
  // in the same cycle it is presented.
  always_comb begin
    stall_out = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_IDLE: stall_out = start & ~fault;
        ST_REQ:  stall_out = 1'b1;
        ST_RESP: stall_out = 1'b1;
        default: stall_out = 1'b0;
      endcase
    end
  end

  assign load_valid_out = ~reset & (state_q == ST_DONE) & ~write_q;
  assign fault_out      = fault_q;
  assign load_data_out  = load_data_q;
  assign req_valid_out  = (state_q == ST_REQ);
  assign req_write_out  = write_q;
  assign req_addr_out   = addr_q;
  assign req_wdata_out  = wdata_q;
  assign req_be_out     = be_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus randomized accesses
// checked against an arithmetic reference model of sizes, lanes and extension.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr_in;
  logic [31:0] store_data_in;
  logic [2:0]  funct3_in;
  logic        memRead_in;
  logic        memWrite_in;
  logic        stall_out;
  logic [31:0] load_data_out;
  logic        load_valid_out;
  logic        fault_out;
  logic        req_valid_out;
  logic        req_ready_in;
  logic        req_write_out;
  logic [31:0] req_addr_out;
  logic [31:0] req_wdata_out;
  logic [3:0]  req_be_out;
  logic        resp_valid_in;
  logic [31:0] resp_rdata_in;

  int checks = 0;
  int failures = 0;
  logic [31:0] last_load = 32'd0;

  mem_access_unit #(.ADDR_WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .addr_in        (addr_in),
    .store_data_in  (store_data_in),
    .funct3_in      (funct3_in),
    .memRead_in     (memRead_in),
    .memWrite_in    (memWrite_in),
    .stall_out      (stall_out),
    .load_data_out  (load_data_out),
    .load_valid_out (load_valid_out),
    .fault_out      (fault_out),
    .req_valid_out  (req_valid_out),
    .req_ready_in   (req_ready_in),
    .req_write_out  (req_write_out),
    .req_addr_out   (req_addr_out),
    .req_wdata_out  (req_wdata_out),
    .req_be_out     (req_be_out),
    .resp_valid_in  (resp_valid_in),
    .resp_rdata_in  (resp_rdata_in)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Access size in bytes, 0 for an unsupported funct3/direction combination.
  function automatic int access_size(input logic [2:0] f3, input logic wr);
    if (wr) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rdata, input int off,
                                             input logic [2:0] f3);
    int sz;
    logic [31:0] v;
    logic [31:0] m;
    sz = access_size(f3, 1'b0);
    if (sz == 4) return rdata;
    v = rdata >> (8 * off);
    m = (32'd1 << (8 * sz)) - 32'd1;
    v = v & m;
    if (f3 < 3'd4 && v[8*sz-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] model_wdata(input logic [31:0] d, input int sz);
    if (sz == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  task automatic check_req(input logic [31:0] a, input logic wr, input logic [3:0] e_be,
                           input logic [31:0] e_wd);
    chk("req_valid", {31'd0, req_valid_out}, 32'd1);
    chk("req_stall", {31'd0, stall_out}, 32'd1);
    chk("req_write", {31'd0, req_write_out}, {31'd0, wr});
    chk("req_addr", req_addr_out, {a[31:2], 2'b00});
    chk("req_be", {28'd0, req_be_out}, {28'd0, e_be});
    if (wr) chk("req_wdata", req_wdata_out, e_wd);
  endtask

  // One complete access, starting and ending at posedge+1 with DUT in IDLE.
  task automatic run_access(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3,
                            input logic rd, input logic wr, input int rdy_dly,
                            input int rsp_dly, input logic [31:0] rdata);
    int sz;
    int off;
    logic flt;
    logic [3:0] e_be;
    logic [31:0] e_wd;
    logic [31:0] e_ld;
    sz   = access_size(f3, wr);
    off  = int'(a[1:0]);
    flt  = (sz == 0) || ((off % (sz == 0 ? 1 : sz)) != 0);
    e_be = wr ? 4'(((1 << sz) - 1) << off) : 4'b1111;
    e_wd = model_wdata(d, sz);
    e_ld = model_load(rdata, off, f3);

    addr_in = a; store_data_in = d; funct3_in = f3; memRead_in = rd; memWrite_in = wr;
    #1;
    chk("present_stall", {31'd0, stall_out}, {31'd0, ~flt});
    if (flt) begin
      step();
      memRead_in = 1'b0; memWrite_in = 1'b0;
      chk("fault_pulse", {31'd0, fault_out}, 32'd1);
      chk("fault_no_req", {31'd0, req_valid_out}, 32'd0);
      chk("fault_stall", {31'd0, stall_out}, 32'd0);
      step();
      chk("fault_clear", {31'd0, fault_out}, 32'd0);
      chk("fault_no_req2", {31'd0, req_valid_out}, 32'd0);
      return;
    end
    step();
    for (int i = 0; i < rdy_dly; i++) begin
      check_req(a, wr, e_be, e_wd);
      step();
    end
    req_ready_in = 1'b1;
    #1;
    check_req(a, wr, e_be, e_wd);
    step();
    req_ready_in = 1'b0;
    if (!wr) begin
      for (int i = 0; i < rsp_dly; i++) begin
        chk("resp_stall", {31'd0, stall_out}, 32'd1);
        chk("resp_no_req", {31'd0, req_valid_out}, 32'd0);
        step();
      end
      chk("resp_stall", {31'd0, stall_out}, 32'd1);
      resp_valid_in = 1'b1; resp_rdata_in = rdata;
      step();
      resp_valid_in = 1'b0; resp_rdata_in = $urandom;
    end
    chk("done_stall", {31'd0, stall_out}, 32'd0);
    chk("done_no_req", {31'd0, req_valid_out}, 32'd0);
    chk("done_load_valid", {31'd0, load_valid_out}, {31'd0, ~wr});
    if (!wr) begin
      chk("done_load_data", load_data_out, e_ld);
      last_load = e_ld;
    end
    memRead_in = 1'b0; memWrite_in = 1'b0;
    step();
    chk("idle_load_valid", {31'd0, load_valid_out}, 32'd0);
    chk("idle_load_hold", load_data_out, last_load);
    chk("idle_stall", {31'd0, stall_out}, 32'd0);
  endtask

  initial begin
    logic [2:0] f3;
    logic [1:0] sel;
    reset = 1'b1; addr_in = '0; store_data_in = '0; funct3_in = '0;
    memRead_in = 1'b0; memWrite_in = 1'b0; req_ready_in = 1'b0;
    resp_valid_in = 1'b0; resp_rdata_in = '0;
    step();
    step();
    chk("rst_stall", {31'd0, stall_out}, 32'd0);
    chk("rst_req_valid", {31'd0, req_valid_out}, 32'd0);
    chk("rst_req_addr", req_addr_out, 32'd0);
    chk("rst_req_be", {28'd0, req_be_out}, 32'd0);
    chk("rst_load_data", load_data_out, 32'd0);
    chk("rst_load_valid", {31'd0, load_valid_out}, 32'd0);
    chk("rst_fault", {31'd0, fault_out}, 32'd0);
    reset = 1'b0;
    step();

    // Directed scenarios.
    run_access(32'h0000_0010, 32'h0, 3'b010, 1'b1, 1'b0, 0, 0, 32'hDEAD_BEEF);
    run_access(32'h0000_0013, 32'h0, 3'b000, 1'b1, 1'b0, 0, 0, 32'h80FF_FFFF);
    run_access(32'h0000_0013, 32'h0, 3'b100, 1'b1, 1'b0, 0, 0, 32'h80FF_FFFF);
    run_access(32'h0000_0012, 32'h0, 3'b101, 1'b1, 1'b0, 0, 0, 32'h80FF_FFFF);
    run_access(32'h0000_0022, 32'h1234_ABCD, 3'b001, 1'b0, 1'b1, 4, 0, 32'h0);
    run_access(32'h0000_0006, 32'h0, 3'b010, 1'b1, 1'b0, 0, 0, 32'h0);
    run_access(32'h0000_0001, 32'h0000_0055, 3'b000, 1'b1, 1'b1, 0, 0, 32'h0);
    chk("sb_both_wdata_last", req_wdata_out, 32'h5555_5555);

    // Reset in RESP with a response still pending.
    addr_in = 32'h40; funct3_in = 3'b010; memRead_in = 1'b1;
    step();
    req_ready_in = 1'b1;
    step();
    req_ready_in = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_stall", {31'd0, stall_out}, 32'd0);
    step();
    memRead_in = 1'b0;
    chk("midrst_req_valid", {31'd0, req_valid_out}, 32'd0);
    chk("midrst_req_write", {31'd0, req_write_out}, 32'd0);
    chk("midrst_req_addr", req_addr_out, 32'd0);
    chk("midrst_req_wdata", req_wdata_out, 32'd0);
    chk("midrst_req_be", {28'd0, req_be_out}, 32'd0);
    chk("midrst_load_data", load_data_out, 32'd0);
    chk("midrst_load_valid", {31'd0, load_valid_out}, 32'd0);
    chk("midrst_fault", {31'd0, fault_out}, 32'd0);
    reset = 1'b0;
    last_load = 32'd0;
    step();
    resp_valid_in = 1'b1; resp_rdata_in = 32'hCAFE_F00D;
    step();
    resp_valid_in = 1'b0;
    chk("late_resp_valid", {31'd0, load_valid_out}, 32'd0);
    chk("late_resp_data", load_data_out, 32'd0);
    chk("late_resp_stall", {31'd0, stall_out}, 32'd0);
    step();
    chk("late_resp_valid2", {31'd0, load_valid_out}, 32'd0);

    // Randomized accesses.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        resp_valid_in = 1'b1; resp_rdata_in = $urandom;
        step();
        resp_valid_in = 1'b0;
        chk("stray_resp_valid", {31'd0, load_valid_out}, 32'd0);
        chk("stray_resp_hold", load_data_out, last_load);
      end
      f3  = 3'($urandom_range(0, 7));
      sel = 2'($urandom_range(1, 3));
      run_access($urandom, $urandom, f3, sel[0], sel[1],
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
